// File: rtl/seven_seg_scan_n.sv
// N-digit multiplexed seven-segment driver.
// Double-buffered digit/dot data (LOAD captures, frame wrap commits), programmable
// refresh divider, leading-zero blanking, per-digit enable and PWM brightness.
// LED_OUT is active-low {dp,g,f,e,d,c,b,a}; SEG_SELECT is an active-low one-hot anode select.
module seven_seg_scan_n #(
   parameter int NUM_DIGITS   = 4,
   parameter int CLK_DIV_MAX  = 99999,
   parameter int BRIGHT_WIDTH = 4
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic [4*NUM_DIGITS-1:0] DIGITS,
   input  logic [NUM_DIGITS-1:0]   DOTS,
   input  logic                    LOAD,
   input  logic [NUM_DIGITS-1:0]   DIGIT_EN,
   input  logic                    LZ_BLANK,
   input  logic [BRIGHT_WIDTH-1:0] BRIGHTNESS,
   output logic [7:0]              LED_OUT,
   output logic [NUM_DIGITS-1:0]   SEG_SELECT,
   output logic                    FRAME_DONE,
   output logic                    PENDING
);

   localparam int DIV_W = (CLK_DIV_MAX > 0) ? $clog2(CLK_DIV_MAX + 1) : 1;
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV_MAX);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [DIV_W-1:0]        div_cnt;
   logic [IDX_W-1:0]        scan_idx;
   logic [BRIGHT_WIDTH-1:0] pwm_cnt;
   logic                    tick;
   logic                    wrap;

   logic [4*NUM_DIGITS-1:0] pend_digits;
   logic [NUM_DIGITS-1:0]   pend_dots;
   logic [4*NUM_DIGITS-1:0] act_digits;
   logic [NUM_DIGITS-1:0]   act_dots;

   logic [NUM_DIGITS-1:0]   blank_mask;
   logic                    zero_above;
   logic [3:0]              cur_digit_p0;
   logic                    cur_blank_p0;
   logic                    anode_on_p0;

   // Hex digit to active-low {g,f,e,d,c,b,a}
   function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
      case (hex)
         4'h0: hex_to_seg = 7'h40;
         4'h1: hex_to_seg = 7'h79;
         4'h2: hex_to_seg = 7'h24;
         4'h3: hex_to_seg = 7'h30;
         4'h4: hex_to_seg = 7'h19;
         4'h5: hex_to_seg = 7'h12;
         4'h6: hex_to_seg = 7'h02;
         4'h7: hex_to_seg = 7'h78;
         4'h8: hex_to_seg = 7'h00;
         4'h9: hex_to_seg = 7'h10;
         4'hA: hex_to_seg = 7'h08;
         4'hB: hex_to_seg = 7'h03;
         4'hC: hex_to_seg = 7'h46;
         4'hD: hex_to_seg = 7'h21;
         4'hE: hex_to_seg = 7'h06;
         default: hex_to_seg = 7'h0E;
      endcase
   endfunction

   assign tick = (div_cnt == DIV_LAST);
   assign wrap = tick && (scan_idx == IDX_LAST);

   // Refresh divider, digit scan index and free-running PWM counter
   always_ff @(posedge CLK) begin
      if (RESET) begin
         div_cnt  <= '0;
         scan_idx <= '0;
         pwm_cnt  <= '0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
         if (tick) begin
            scan_idx <= wrap ? '0 : scan_idx + IDX_W'(1);
         end
         pwm_cnt <= pwm_cnt + BRIGHT_WIDTH'(1);
      end
   end

   // Pending/active double buffer; the active copy only changes at a frame wrap
   always_ff @(posedge CLK) begin
      if (RESET) begin
         pend_digits <= '0;
         pend_dots   <= '0;
         act_digits  <= '0;
         act_dots    <= '0;
         PENDING     <= 1'b0;
         FRAME_DONE  <= 1'b0;
      end else begin
         FRAME_DONE <= wrap;
         if (LOAD) begin
            pend_digits <= DIGITS;
            pend_dots   <= DOTS;
         end
         if (wrap) begin
            // A LOAD on the wrap tick bypasses the pending stage entirely
            act_digits <= LOAD ? DIGITS : pend_digits;
            act_dots   <= LOAD ? DOTS : pend_dots;
            PENDING    <= 1'b0;
         end else if (LOAD) begin
            PENDING <= 1'b1;
         end
      end
   end

   // Leading-zero mask: digit i blanks when it and every digit above it are zero
   always_comb begin
      zero_above = 1'b1;
      blank_mask = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_above    = zero_above && (act_digits[4*i +: 4] == 4'h0);
         blank_mask[i] = (i != 0) && zero_above;
      end
   end

   assign cur_digit_p0 = act_digits[4*scan_idx +: 4];
   assign cur_blank_p0 = LZ_BLANK && blank_mask[scan_idx];
   assign anode_on_p0  = (pwm_cnt <= BRIGHTNESS) && DIGIT_EN[scan_idx];

   // Registered pin drive: segments and anode for the currently scanned digit
   always_ff @(posedge CLK) begin
      if (RESET) begin
         LED_OUT    <= 8'hFF;
         SEG_SELECT <= '1;
      end else if (anode_on_p0) begin
         LED_OUT    <= {~act_dots[scan_idx], cur_blank_p0 ? 7'h7F : hex_to_seg(cur_digit_p0)};
         SEG_SELECT <= ~(NUM_DIGITS'(1) << scan_idx);
      end else begin
         LED_OUT    <= 8'hFF;
         SEG_SELECT <= '1;
      end
   end

endmodule
